// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS
// datapath. The program counter drives instruction memory directly. The
// returned word and PC+4 are captured into IF/ID, where the decode stage
// picks them up. A wrapping counter tracks how many real instructions have
// entered IF/ID, for performance measurements.
//
// Per-edge priority, highest first:
//   Redirect  -> PC jumps to the word-aligned target; IF/ID flushed to a bubble
//   Stall     -> PC, IF/ID and FetchCount all hold
//   IMem_Ready=1 -> instruction captured; PC advances by 4; count increments
//   IMem_Ready=0 -> PC holds; a bubble is inserted into IF/ID
//
// Parameters:
//   RESET_PC  PC value loaded on reset (must be word aligned)
//   CNT_W     width of FetchCount
//
// Ports:
//   Clk                in   clock, rising edge
//   Rst_n              in   asynchronous active-low reset
//   Stall              in   hazard-unit stall (hold PC and IF/ID)
//   Redirect           in   taken branch/jump resolved in EX
//   RedirectPC         in   redirect target; bits [1:0] are ignored
//   IMem_Ready         in   instruction memory data valid this cycle
//   IMem_Data          in   instruction word at IMem_Addr
//   IMem_Addr          out  current PC, zero latency
//   IMem_Req           out  fetch request (~Stall & ~Redirect, 0 in reset)
//   IF_ID_Instruction  out  registered instruction for decode
//   IF_ID_PCPlus4      out  registered PC+4 of that instruction
//   IF_ID_Valid        out  IF/ID holds a real instruction (0 = bubble)
//   PC                 out  current program counter
//   FetchCount         out  valid instructions loaded into IF/ID, wrapping
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [31:0]      RedirectPC,
  input  logic             IMem_Ready,
  input  logic [31:0]      IMem_Data,
  output logic [31:0]      IMem_Addr,
  output logic             IMem_Req,
  output logic [31:0]      IF_ID_Instruction,
  output logic [31:0]      IF_ID_PCPlus4,
  output logic             IF_ID_Valid,
  output logic [31:0]      PC,
  output logic [CNT_W-1:0] FetchCount
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;

  // Modulo-2^32 increment; wraps silently from 0xFFFF_FFFC to 0.
  assign pc_plus4 = pc_q + 32'd4;

  // Masking (rather than slicing) keeps every RedirectPC bit in use while
  // forcing word alignment of the target.
  assign redirect_target = RedirectPC & ~32'h0000_0003;

  assign PC        = pc_q;
  assign IMem_Addr = pc_q;

  // Reset gates the request combinationally so memory sees no request while
  // Rst_n is low, even between clock edges.
  assign IMem_Req = Rst_n & ~Stall & ~Redirect;

  // NOTE: all pipeline state uses non-blocking assignments so every register
  // samples pre-edge values; only the PC/IF-ID flops are reset (no memories).
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q              <= RESET_PC;
      IF_ID_Instruction <= NOP;
      IF_ID_PCPlus4     <= 32'h0000_0000;
      IF_ID_Valid       <= 1'b0;
      FetchCount        <= '0;
    end else if (Redirect) begin
      // Flush the wrong-path instruction; the target is fetched next cycle.
      pc_q              <= redirect_target;
      IF_ID_Instruction <= NOP;
      IF_ID_PCPlus4     <= 32'h0000_0000;
      IF_ID_Valid       <= 1'b0;
    end else if (Stall) begin
      // Everything holds; the held instruction is delivered exactly once
      // when the stall drops.
      pc_q              <= pc_q;
    end else if (IMem_Ready) begin
      pc_q              <= pc_plus4;
      IF_ID_Instruction <= IMem_Data;
      IF_ID_PCPlus4     <= pc_plus4;
      IF_ID_Valid       <= 1'b1;
      FetchCount        <= FetchCount + CNT_W'(1);
    end else begin
      // Memory wait state: retry the same PC and pass a bubble to decode.
      IF_ID_Instruction <= NOP;
      IF_ID_PCPlus4     <= 32'h0000_0000;
      IF_ID_Valid       <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS datapath. Holds the program counter, presents it to instruction memory, and registers the returned word plus PC+4 into IF/ID, where the decode-stage control unit consumes it. Supports load-use stalls from the hazard unit, taken-branch/jump redirects from EX, and instruction-memory wait states. Also keeps a fetched-instruction counter for lab performance measurements.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 16, width of FetchCount.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Stall  in  1  hazard-unit stall; hold PC and IF/ID.
- Redirect  in  1  taken branch/jump resolved in EX.
- RedirectPC  in  32  target address for Redirect.
- IMem_Ready  in  1  instruction memory has valid data this cycle.
- IMem_Data  in  32  instruction word at IMem_Addr, combinational read.
- IMem_Addr  out  32  current PC (combinational from PC register).
- IMem_Req  out  1  fetch request: ~Stall & ~Redirect, 0 in reset.
- IF_ID_Instruction  out  32  registered instruction for decode.
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- PC  out  32  current program counter.
- FetchCount  out  CNT_W  number of valid instructions loaded into IF/ID, wrapping.

## Operation

- Reset (Rst_n=0, asynchronous): PC=RESET_PC; IF_ID_Instruction=32'h0000_0000 (NOP); IF_ID_PCPlus4=0; IF_ID_Valid=0; FetchCount=0. IMem_Req=0 while Rst_n=0.
- Per-edge priority, highest first: Redirect, Stall, normal fetch.
- Redirect=1 (overrides Stall): PC <= {RedirectPC[31:2],2'b00}; IF/ID flushed to NOP, Valid=0, PCPlus4=0; FetchCount unchanged.
- Stall=1, Redirect=0: PC, all IF/ID outputs and FetchCount hold.
- Normal, IMem_Ready=1: IF_ID_Instruction <= IMem_Data; IF_ID_PCPlus4 <= PC+4; IF_ID_Valid <= 1; PC <= PC+4; FetchCount <= FetchCount+1.
- Normal, IMem_Ready=0: PC holds; IF/ID loaded with bubble (NOP, Valid=0, PCPlus4=0); FetchCount holds.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000, no flag. FetchCount wraps from all-ones to 0.
- RedirectPC bits [1:0] ignored (forced word alignment).
- No internal state machine beyond PC/IF-ID registers; the module never stalls itself except via IMem_Ready.

## Timing

- IMem_Addr = PC same cycle, zero latency.
- Fetch latency: instruction at address A appears on IF/ID one edge after PC=A with IMem_Ready=1.
- Redirect asserted in cycle n: PC=target after edge n; IF/ID bubble during n+1; target instruction in IF/ID after edge n+1 (if IMem_Ready=1): two-cycle taken-branch penalty, one bubble.
- Stall held k cycles: PC and IF/ID frozen exactly k cycles; the held instruction is delivered once, never duplicated or dropped.
- Stall and IMem_Ready=0 together: Stall wins (IF/ID holds, no bubble inserted).
- Reset released mid-operation: first fetch at RESET_PC on the first edge with Rst_n=1; IF_ID_Valid=0 until then.
- Rst_n asserted mid-cycle: outputs go to reset values immediately, independent of Clk.

## Test plan

- Reset, RESET_PC=0, IMem_Ready=1, memory word i = 32'h2000_0000+i: after 3 edges PC=0x0C, IF_ID_Instruction=32'h2000_0002, IF_ID_PCPlus4=0x0C, FetchCount=3.
- Stall for 2 cycles while IF/ID holds word at 0x08: IF/ID and PC unchanged for both cycles; next edge loads word at 0x0C; FetchCount increments once.
- Redirect=1, RedirectPC=0x0000_0103 with Stall=1 same cycle: PC becomes 0x100, IF_ID_Valid=0, IF_ID_Instruction=0; following edge IF_ID_PCPlus4=0x104, Valid=1.
- IMem_Ready=0 for 3 cycles at PC=0x20: PC stays 0x20, three bubbles (Valid=0), FetchCount unchanged; Ready=1 then loads word at 0x20.
- RESET_PC=32'hFFFF_FFFC: first fetch gives IF_ID_PCPlus4=0, PC=0; FetchCount preset near wrap (run 2^16 fetches) returns to 0.
- Assert Rst_n=0 between edges during fetch at PC=0x40: PC, IF/ID, FetchCount reset asynchronously before next Clk edge; IMem_Req=0.
